// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slot bundle between a master and one SRAM responder.
// Common bus signals plus the slot's select and response lines.
interface ahb_sram_slave_if;
  logic        sel;
  logic [31:0] addr;
  logic        write;
  logic [2:0]  size;
  logic [2:0]  burst;
  logic [3:0]  prot;
  logic [1:0]  trans;
  logic        mastlock;
  logic        ready_in;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready_out;
  logic        resp;

  modport master (
    output sel, addr, write, size, burst,
    output prot, trans, mastlock, ready_in,
    output wdata,
    input  rdata, ready_out, resp
  );

  modport slave (
    input  sel, addr, write, size, burst,
    input  prot, trans, mastlock, ready_in,
    input  wdata,
    output rdata, ready_out, resp
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word SRAM responder with wait states and two-cycle ERROR.
// Define AHB_SLV_PROT_CHECK_EN to reject user writes to the low region.
module ahb_sram_slave #(
  parameter int DEPTH_BYTES     = 2048,
  parameter int WAIT_STATES     = 0,
  parameter int PROTECTED_BYTES = 256
) (
  input logic        i_clock,
  input logic        i_reset,
  ahb_sram_slave_if.slave s_ahb
);
  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        r_state;
  state_t        w_nstate;
  logic [3:0]    r_cnt;
  logic [3:0]    w_ncnt;
  logic [AW-1:0] r_addr;
  logic          r_write;
  logic [1:0]    r_size;
  logic [31:0]   r_mem [WORDS];

  logic          w_open;
  logic          w_accept;
  logic          w_size_err;
  logic          w_align_err;
  logic          w_range_err;
  logic          w_prot_err;
  logic          w_err;
  logic          w_ready;
  logic          w_resp;
  logic [3:0]    w_be;
  logic [AW-3:0] w_idx;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_open = (r_state == S_IDLE) ||
                  (r_state == S_DATA) ||
                  (r_state == S_ERR2);

  assign w_accept = s_ahb.sel &
                    s_ahb.ready_in &
                    s_ahb.trans[1] &
                    w_open;

  assign w_size_err = s_ahb.size > 3'd2;

  assign w_align_err =
    ((s_ahb.size == 3'd1) && s_ahb.addr[0]) ||
    ((s_ahb.size == 3'd2) && (s_ahb.addr[1:0] != 2'b00));

  assign w_range_err = s_ahb.addr >= 32'(DEPTH_BYTES);

`ifdef AHB_SLV_PROT_CHECK_EN
  assign w_prot_err = s_ahb.write &
                      ~s_ahb.prot[1] &
                      (s_ahb.addr < 32'(PROTECTED_BYTES));
  assign w_unused = ^{s_ahb.burst, s_ahb.mastlock,
                      s_ahb.prot[3:2], s_ahb.prot[0]};
`else
  assign w_prot_err = 1'b0;
  assign w_unused = ^{s_ahb.burst, s_ahb.mastlock,
                      s_ahb.prot, PROTECTED_BYTES[0]};
`endif

  assign w_err = w_size_err | w_align_err |
                 w_range_err | w_prot_err;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= 2'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      if (w_accept) begin
        r_addr  <= s_ahb.addr[AW-1:0];
        r_write <= s_ahb.write;
        r_size  <= s_ahb.size[1:0];
      end
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_ready  = 1'b1;
    w_resp   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        w_resp = (r_state == S_ERR2);
        if (!w_accept) begin
          w_nstate = S_IDLE;
        end else if (w_err) begin
          w_nstate = S_ERR1;
        end else if (WAIT_STATES > 0) begin
          w_nstate = S_WAIT;
          w_ncnt   = WS_LOAD;
        end else begin
          w_nstate = S_DATA;
        end
      end
      S_WAIT: begin
        w_ready = 1'b0;
        if (r_cnt == 4'd0) begin
          w_nstate = S_DATA;
        end else begin
          w_ncnt = r_cnt - 4'd1;
        end
      end
      S_ERR1: begin
        w_ready  = 1'b0;
        w_resp   = 1'b1;
        w_nstate = S_ERR2;
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_be = 4'b0000;
    unique case (1'b1)
      (r_size == 2'd0): w_be = 4'b0001 << r_addr[1:0];
      (r_size == 2'd1): w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default:          w_be = 4'b1111;
    endcase
  end

  assign w_idx = r_addr[AW-1:2];

  // Commit lands on the edge that ends DATA, so a pipelined read sees it.
  always_ff @(posedge i_clock) begin
    if ((r_state == S_DATA) && r_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= s_ahb.wdata[8*i +: 8];
        end
      end
    end
  end

  assign w_rdata = ((r_state == S_DATA) && !r_write) ?
                   r_mem[w_idx] : 32'd0;

  assign s_ahb.rdata     = w_rdata;
  assign s_ahb.ready_out = w_ready;
  assign s_ahb.resp      = w_resp;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised pipelined AHB-Lite master against a byte-level memory model.
// Two instances: zero wait states and three wait states.
module tb_ahb_sram_slave;
  localparam int DB  = 2048;
  localparam int PB  = 256;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] wd;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_sel;
  logic [31:0] a_addr;
  logic        a_write;
  logic [2:0]  a_size;
  logic [2:0]  a_burst;
  logic [3:0]  a_prot;
  logic [1:0]  a_trans;
  logic [31:0] a_wdata;
  int          act;

  ahb_sram_slave_if b0();
  ahb_sram_slave_if b1();

  assign b0.sel      = a_sel && (act == 0);
  assign b1.sel      = a_sel && (act == 1);
  assign b0.addr     = a_addr;
  assign b1.addr     = a_addr;
  assign b0.write    = a_write;
  assign b1.write    = a_write;
  assign b0.size     = a_size;
  assign b1.size     = a_size;
  assign b0.burst    = a_burst;
  assign b1.burst    = a_burst;
  assign b0.prot     = a_prot;
  assign b1.prot     = a_prot;
  assign b0.trans    = a_trans;
  assign b1.trans    = a_trans;
  assign b0.mastlock = 1'b0;
  assign b1.mastlock = 1'b0;
  assign b0.wdata    = a_wdata;
  assign b1.wdata    = a_wdata;
  assign b0.ready_in = b0.ready_out;
  assign b1.ready_in = b1.ready_out;

  ahb_sram_slave #(
    .DEPTH_BYTES(DB), .WAIT_STATES(WS0),
    .PROTECTED_BYTES(PB)
  ) u0 (.i_clock(clk), .i_reset(rst), .s_ahb(b0));

  ahb_sram_slave #(
    .DEPTH_BYTES(DB), .WAIT_STATES(WS1),
    .PROTECTED_BYTES(PB)
  ) u1 (.i_clock(clk), .i_reset(rst), .s_ahb(b1));

  int checks   = 0;
  int failures = 0;
  logic [31:0] mm [2][DB/4];
  xfer_t q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int ws(input int d);
    return (d != 0) ? WS1 : WS0;
  endfunction

  function automatic xfer_t idle_x();
    xfer_t x = '0;
    return x;
  endfunction

  function automatic xfer_t mk(input bit wr,
                               input logic [31:0] a,
                               input logic [2:0] sz,
                               input logic [31:0] wd,
                               input logic [3:0] pr);
    xfer_t x;
    x.sel = 1'b1; x.trans = 2'd2; x.addr = a;
    x.wr = wr; x.size = sz; x.prot = pr; x.wd = wd;
    return x;
  endfunction

  function automatic bit is_act(input xfer_t x);
    return x.sel && x.trans[1];
  endfunction

  function automatic bit is_err(input xfer_t x);
    int nb;
    bit e;
    nb = 1 << x.size;
    e = (x.size > 3'd2) || ((x.addr % nb) != 0) ||
        (x.addr >= DB);
`ifdef AHB_SLV_PROT_CHECK_EN
    if (x.wr && !x.prot[1] && x.addr < PB) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic mwrite(input int d, input xfer_t x);
    int wi, f, n;
    logic [31:0] w;
    wi = int'(x.addr) / 4;
    f  = int'(x.addr) % 4;
    n  = 1 << x.size;
    w  = mm[d][wi];
    for (int k = f; k < f + n; k++) w[8*k +: 8] = x.wd[8*k +: 8];
    mm[d][wi] = w;
  endtask

  function automatic xfer_t rnd();
    xfer_t x;
    x.sel = ($urandom_range(0, 7) != 0);
    x.trans = ($urandom_range(0, 4) == 0) ?
              2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
    x.size = ($urandom_range(0, 9) == 0) ?
             3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    x.addr = ($urandom_range(0, 9) == 0) ?
             32'h800 + 32'($urandom_range(0, 255)) :
             32'($urandom_range(0, 255));
    if (x.size <= 3'd2 && $urandom_range(0, 3) != 0)
      x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
    x.wr = 1'($urandom_range(0, 1));
    x.prot = 4'($urandom_range(0, 15));
    x.wd = $urandom;
    return x;
  endfunction

  task automatic drive(input xfer_t x);
    a_sel   = x.sel;
    a_trans = x.trans;
    a_addr  = x.addr;
    a_write = x.wr;
    a_size  = x.size;
    a_prot  = x.prot;
    a_burst = 3'($urandom_range(0, 7));
  endtask

  task automatic run(input int d);
    xfer_t cur, dp;
    bit dpv, e, rdy, rsp;
    logic [31:0] rd, er;
    int cyc, waits;
    act = d;
    dpv = 1'b0;
    waits = 0;
    cyc = 0;
    dp = idle_x();
    cur = (q.size() != 0) ? q.pop_front() : idle_x();
    drive(cur);
    while ((q.size() != 0 || dpv || is_act(cur)) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      rdy = (d != 0) ? b1.ready_out : b0.ready_out;
      rsp = (d != 0) ? b1.resp : b0.resp;
      rd  = (d != 0) ? b1.rdata : b0.rdata;
      if (dpv) begin
        e = is_err(dp);
        if (!rdy) begin
          waits++;
          chk("wait_resp", 32'(rsp), 32'(e));
          chk("wait_rdata", rd, 32'd0);
          if (waits > 20) begin
            chk("wait_timeout", 32'(waits), 32'd20);
            dpv = 1'b0;
          end
        end else begin
          chk("resp", 32'(rsp), 32'(e));
          chk("nwait", 32'(waits), e ? 32'd1 : 32'(ws(d)));
          er = (!e && !dp.wr) ? mm[d][int'(dp.addr) / 4] : 32'd0;
          chk(dp.wr ? "wr_rdata" : "rd_rdata", rd, er);
          if (!e && dp.wr) mwrite(d, dp);
          dpv = 1'b0;
        end
      end else begin
        chk("idle_ready", 32'(rdy), 32'd1);
        chk("idle_resp", 32'(rsp), 32'd0);
        chk("idle_rdata", rd, 32'd0);
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        if (is_act(cur)) begin
          dp = cur;
          dpv = 1'b1;
          waits = 0;
        end
        a_wdata = cur.wd;
        cur = (q.size() != 0) ? q.pop_front() : idle_x();
        drive(cur);
      end
    end
    chk("run_done", 32'(cyc < 4000), 32'd1);
    drive(idle_x());
  endtask

  task automatic preload(input int d);
    logic [31:0] v;
    for (int a = 0; a < 256; a += 4) begin
      v = $urandom;
      q.push_back(mk(1'b1, 32'(a), 3'd2, v, 4'h2));
    end
    run(d);
  endtask

  initial begin
    act = 0;
    a_wdata = 32'd0;
    drive(idle_x());
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 32'(b0.ready_out), 32'd1);
    chk("rst_resp0", 32'(b0.resp), 32'd0);
    chk("rst_rdata0", b0.rdata, 32'd0);
    chk("rst_ready1", 32'(b1.ready_out), 32'd1);
    chk("rst_resp1", 32'(b1.resp), 32'd0);
    chk("rst_rdata1", b1.rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    preload(0);
    q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 4'h2));
    q.push_back(mk(1'b0, 32'h10, 3'd2, $urandom, 4'h2));
    q.push_back(mk(1'b1, 32'h20, 3'd2, 32'h11223344, 4'h2));
    q.push_back(mk(1'b1, 32'h21, 3'd0, 32'h9977AA66, 4'h2));
    q.push_back(mk(1'b0, 32'h20, 3'd2, $urandom, 4'h2));
    q.push_back(mk(1'b1, 32'h22, 3'd1, 32'h5566BEEF, 4'h2));
    q.push_back(mk(1'b0, 32'h20, 3'd2, $urandom, 4'h2));
    q.push_back(mk(1'b0, 32'h802, 3'd2, $urandom, 4'h2));
    q.push_back(mk(1'b0, 32'h0, 3'd2, $urandom, 4'h2));
    q.push_back(mk(1'b1, 32'h800, 3'd2, 32'hCAFEF00D, 4'h2));
    q.push_back(mk(1'b0, 32'h0, 3'd2, $urandom, 4'h2));
    q.push_back(mk(1'b1, 32'h10, 3'd2, 32'h0BADF00D, 4'h0));
    q.push_back(mk(1'b0, 32'h10, 3'd2, $urandom, 4'h0));
    q.push_back(mk(1'b1, 32'h10, 3'd2, 32'h600DCAFE, 4'h2));
    q.push_back(mk(1'b0, 32'h10, 3'd2, $urandom, 4'h0));
    q.push_back(mk(1'b1, 32'h100, 3'd2, 32'h13572468, 4'h0));
    q.push_back(mk(1'b0, 32'h100, 3'd2, $urandom, 4'h0));
    run(0);
    for (int i = 0; i < 200; i++) q.push_back(rnd());
    run(0);

    preload(1);
    q.push_back(mk(1'b0, 32'h0, 3'd2, $urandom, 4'h2));
    q.push_back(mk(1'b1, 32'h4, 3'd2, 32'hA5A5C3C3, 4'h2));
    q.push_back(mk(1'b0, 32'h4, 3'd2, $urandom, 4'h2));
    q.push_back(mk(1'b0, 32'h3, 3'd1, $urandom, 4'h2));
    run(1);

    act = 1;
    drive(mk(1'b1, 32'h40, 3'd2, 32'd0, 4'h2));
    @(posedge clk);
    #1;
    drive(idle_x());
    a_wdata = 32'h12345678;
    @(negedge clk);
    chk("rstw_wait", 32'(b1.ready_out), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rstw_ready", 32'(b1.ready_out), 32'd1);
    chk("rstw_resp", 32'(b1.resp), 32'd0);
    chk("rstw_rdata", b1.rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.push_back(mk(1'b0, 32'h40, 3'd2, $urandom, 4'h2));
    run(1);
    for (int i = 0; i < 120; i++) q.push_back(rnd());
    run(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
